cache_write_merge: RTL and testbench

Registered write-merge stage for the LC3B cache data path. It accepts a CPU store (16-bit data, byte mask, target set) together with the current 128-bit cache line and the one-hot word select from the offset decoder. It produces the merged line in a one-entry output register, which drains to the data-array write port through a valid/ready handshake. Optionally, it folds back-to-back stores to the same set into the held line.

---
 rtl/cache_write_merge.sv | 90 +++++++++
 tb/tb_cache_write_merge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cache_write_merge.sv
// Registered write-merge stage: merges a 16-bit store into a 128-bit cache line and holds it for the data-array write port.
// Optional `WRITE_COALESCE_EN folds same-set stores into the held line.
module cache_write_merge (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_set,
  input  logic [7:0]   req_word_sel,
  input  logic [1:0]   req_wmask,
  input  logic [15:0]  req_wdata,
  input  logic [127:0] req_line,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_set,
  output logic [127:0] out_line,
  output logic         sel_err
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e         state_q, state_d;
  logic [127:0]   line_q, line_d;
  logic [2:0]     set_q, set_d;
  logic           err_q, err_d;
  logic           coalesce_hit;
  logic [127:0]   base_line;
  logic [127:0]   merged;
  logic           sel_ok;
  logic           accept;

`ifdef WRITE_COALESCE_EN
  // Same-set hit uses the held line as base, including on a drain cycle.
  assign coalesce_hit = (state_q == FULL) && (req_set == set_q);
  assign base_line    = coalesce_hit ? line_q : req_line;
`else
  assign coalesce_hit = 1'b0;
  assign base_line    = req_line;
`endif

  assign req_ready = (state_q == EMPTY) || out_ready || coalesce_hit;
  assign accept    = req_valid && req_ready;
  assign sel_ok    = (req_word_sel != '0) &&
                     ((req_word_sel & (req_word_sel - 8'd1)) == '0);

  always_comb begin
    merged = base_line;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sel_ok && req_word_sel[i]) begin
        if (req_wmask[0]) merged[16*i +: 8]     = req_wdata[7:0];
        if (req_wmask[1]) merged[16*i + 8 +: 8] = req_wdata[15:8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    set_d   = set_q;
    err_d   = err_q;
    if (accept) begin
      state_d = FULL;
      line_d  = merged;
      set_d   = req_set;
      err_d   = err_q || !sel_ok;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      line_q  <= '0;
      set_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      set_q   <= set_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_line  = line_q;
  assign out_set   = set_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_cache_write_merge.sv
// Directed bench for cache_write_merge: vector table plus backpressure, coalesce and reset sequences.
// Coalesce expectations follow `WRITE_COALESCE_EN.
module tb_cache_write_merge;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_set;
  logic [7:0]   req_word_sel;
  logic [1:0]   req_wmask;
  logic [15:0]  req_wdata;
  logic [127:0] req_line;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_set;
  logic [127:0] out_line;
  logic         sel_err;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  cache_write_merge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_word_sel(req_word_sel),
    .req_wmask(req_wmask), .req_wdata(req_wdata), .req_line(req_line),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_set(out_set), .out_line(out_line), .sel_err(sel_err)
  );

  typedef struct {
    logic [2:0]   set;
    logic [7:0]   sel;
    logic [1:0]   wm;
    logic [15:0]  wd;
    logic [127:0] line;
    logic [127:0] exp_line;
    logic         exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] sel,
                       input logic [1:0] wm, input logic [15:0] wd, input logic [127:0] ln);
    req_valid    = v;
    req_set      = s;
    req_word_sel = sel;
    req_wmask    = wm;
    req_wdata    = wd;
    req_line     = ln;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, '0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [127:0] held_line;
  logic [2:0]   held_set;

  initial begin
    vecs[0] = '{3'd2, 8'h04, 2'b11, 16'hBEEF, {8{16'h1111}},
                {{5{16'h1111}}, 16'hBEEF, {2{16'h1111}}}, 1'b0};
    vecs[1] = '{3'd3, 8'h80, 2'b01, 16'hAB12, {16'h3456, {7{16'h0000}}},
                {16'h3412, {7{16'h0000}}}, 1'b0};
    vecs[2] = '{3'd4, 8'h80, 2'b10, 16'hAB12, {16'h3456, {7{16'h0000}}},
                {16'hAB56, {7{16'h0000}}}, 1'b0};
    vecs[3] = '{3'd1, 8'h01, 2'b00, 16'hFFFF, {8{16'hA5A5}},
                {8{16'hA5A5}}, 1'b0};
    vecs[4] = '{3'd0, 8'h10, 2'b11, 16'h1234, {8{16'h0000}},
                {{3{16'h0000}}, 16'h1234, {4{16'h0000}}}, 1'b0};
    vecs[5] = '{3'd6, 8'h00, 2'b11, 16'hFFFF, {8{16'h5A5A}},
                {8{16'h5A5A}}, 1'b1};
    vecs[6] = '{3'd7, 8'h03, 2'b11, 16'hFFFF, {8{16'hC3C3}},
                {8{16'hC3C3}}, 1'b1};
    vecs[7] = '{3'd2, 8'h02, 2'b11, 16'h7777, {8{16'h0000}},
                {{6{16'h0000}}, 16'h7777, 16'h0000}, 1'b1};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_out_line", out_line, 128'd0);
    check("reset_out_set", {125'd0, out_set}, 128'd0);
    check("reset_sel_err", {127'd0, sel_err}, 128'd0);
    check("reset_req_ready", {127'd0, req_ready}, 128'd1);
    @(negedge clk);
    rst = 1'b0;

    // Table: back-to-back stores, out_ready high, alternating sets.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(1'b1, vecs[i].set, vecs[i].sel, vecs[i].wm, vecs[i].wd, vecs[i].line);
      #1;
      check($sformatf("v%0d_req_ready", i), {127'd0, req_ready}, 128'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", i), {127'd0, out_valid}, 128'd1);
      check($sformatf("v%0d_out_set", i), {125'd0, out_set}, {125'd0, vecs[i].set});
      check($sformatf("v%0d_out_line", i), out_line, vecs[i].exp_line);
      check($sformatf("v%0d_sel_err", i), {127'd0, sel_err}, {127'd0, vecs[i].exp_err});
    end

    // Drain with no new request empties the register; sticky error survives.
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, '0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_out_valid", {127'd0, out_valid}, 128'd0);
    check("drain_sel_err", {127'd0, sel_err}, 128'd1);

    do_reset();
    #1;
    check("rst_clears_sel_err", {127'd0, sel_err}, 128'd0);

    // Backpressure: FULL, out_ready low, different-set request stalls.
    @(negedge clk);
    drive(1'b1, 3'd2, 8'h04, 2'b11, 16'hBEEF, {8{16'h1111}});
    out_ready = 1'b1;
    @(posedge clk); #1;
    held_line = {{5{16'h1111}}, 16'hBEEF, {2{16'h1111}}};
    held_set  = 3'd2;
    check("bp_load_line", out_line, held_line);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'd5, 8'h01, 2'b11, 16'hCAFE, {8{16'h2222}});
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_req_ready", c), {127'd0, req_ready}, 128'd0);
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_valid", c), {127'd0, out_valid}, 128'd1);
      check($sformatf("bp%0d_out_line", c), out_line, held_line);
      check($sformatf("bp%0d_out_set", c), {125'd0, out_set}, {125'd0, held_set});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_req_ready", {127'd0, req_ready}, 128'd1);
    @(posedge clk); #1;
    check("bp_release_out_valid", {127'd0, out_valid}, 128'd1);
    check("bp_release_out_set", {125'd0, out_set}, 128'd5);
    check("bp_release_out_line", out_line, {{7{16'h2222}}, 16'hCAFE});

    do_reset();

    // Same-set stores while the output is stalled.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'd5, 8'h01, 2'b11, 16'h0001, {8{16'h0000}});
    @(posedge clk); #1;
    check("co_first_line", out_line, {{7{16'h0000}}, 16'h0001});
    @(negedge clk);
    drive(1'b1, 3'd5, 8'h08, 2'b11, 16'h0003, {8{16'hFFFF}});
    #1;
`ifdef WRITE_COALESCE_EN
    check("co_req_ready", {127'd0, req_ready}, 128'd1);
    @(posedge clk); #1;
    check("co_merged_line", out_line,
          {{4{16'h0000}}, 16'h0003, {2{16'h0000}}, 16'h0001});
`else
    check("co_req_ready", {127'd0, req_ready}, 128'd0);
    @(posedge clk); #1;
    check("co_merged_line", out_line, {{7{16'h0000}}, 16'h0001});
`endif
    check("co_out_valid", {127'd0, out_valid}, 128'd1);

    // Reset while FULL and stalled discards the held line.
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_out_line", out_line, 128'd0);
    check("midrst_req_ready", {127'd0, req_ready}, 128'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
